// File: rtl/types_pkg.sv
// Shared pipeline types: register index, data word and writeback arbiter types.
package types_pkg;

    typedef logic [4:0]  reg_t;
    typedef logic [63:0] dword_t;

    typedef enum logic {
        MEM_FIRST = 1'b0,
        EX_FIRST  = 1'b1
    } wb_arb_state_t;

    typedef struct packed {
        logic   req;
        reg_t   rd;
        dword_t wdata;
    } wb_req_t;

    localparam reg_t ZERO_REG = 5'd0;

    // A request only needs the write port when it targets a real register.
    function automatic logic is_real_write(input wb_req_t r);
        return r.req && (r.rd != ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the writeback arbiter signals, in the same shape as registers_if.
interface regfile_wb_arbiter_if
    import types_pkg::*;
(
    input logic CLK
);
    logic   nRST;
    logic   ex_req,  mem_req;
    reg_t   ex_rd,   mem_rd;
    dword_t ex_wdata, mem_wdata;
    logic   ex_gnt,  mem_gnt;
    reg_t   rs1, rs2, rf_rs1, rf_rs2;
    dword_t rf_rdata1, rf_rdata2, rdata1, rdata2;
    reg_t   rf_rd;
    dword_t rf_wdata;
    logic   rf_RegWrite;

    modport arb (
        input  CLK, nRST, ex_req, ex_rd, ex_wdata, mem_req, mem_rd, mem_wdata,
               rs1, rs2, rf_rdata1, rf_rdata2,
        output ex_gnt, mem_gnt, rf_rs1, rf_rs2, rdata1, rdata2,
               rf_rd, rf_wdata, rf_RegWrite
    );

    modport tb (
        input  CLK, ex_gnt, mem_gnt, rf_rs1, rf_rs2, rdata1, rdata2,
               rf_rd, rf_wdata, rf_RegWrite,
        output nRST, ex_req, ex_rd, ex_wdata, mem_req, mem_rd, mem_wdata,
               rs1, rs2, rf_rdata1, rf_rdata2
    );
endinterface

// File: rtl/rf_fwd_mux.sv
// One read-port bypass: returns the in-flight registered write when it targets rs.
module rf_fwd_mux
    import types_pkg::*;
(
    input  logic   wr_en,
    input  reg_t   wr_rd,
    input  dword_t wr_data,
    input  reg_t   rs,
    input  dword_t rf_rdata,
    output dword_t rdata
);
    // x0 is never forwarded; the register file already returns zero for it.
    always_comb begin
        rdata = rf_rdata;
        if (wr_en && (wr_rd == rs) && (rs != ZERO_REG)) begin
            rdata = wr_data;
        end else begin
            rdata = rf_rdata;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register file write port between ex and mem writeback,
// registers the winner for one cycle and bypasses it onto both read ports.
module regfile_wb_arbiter
    import types_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic   CLK,
    input  logic   nRST,
    input  logic   ex_req,
    input  reg_t   ex_rd,
    input  dword_t ex_wdata,
    output logic   ex_gnt,
    input  logic   mem_req,
    input  reg_t   mem_rd,
    input  dword_t mem_wdata,
    output logic   mem_gnt,
    input  reg_t   rs1,
    input  reg_t   rs2,
    output reg_t   rf_rs1,
    output reg_t   rf_rs2,
    input  dword_t rf_rdata1,
    input  dword_t rf_rdata2,
    output dword_t rdata1,
    output dword_t rdata2,
    output reg_t   rf_rd,
    output dword_t rf_wdata,
    output logic   rf_RegWrite
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    wb_arb_state_t state_r, state_next_s;
    logic [3:0]    starve_cnt_r, starve_cnt_next_s;
    wb_req_t       ex_s, mem_s;
    logic          ex_real_s, mem_real_s, ex_win_s, mem_win_s;

    assign ex_s       = '{req: ex_req,  rd: ex_rd,  wdata: ex_wdata};
    assign mem_s      = '{req: mem_req, rd: mem_rd, wdata: mem_wdata};
    assign ex_real_s  = is_real_write(ex_s);
    assign mem_real_s = is_real_write(mem_s);

    // Pick the port winner; x0 requests never compete for the port.
    always_comb begin
        ex_win_s  = 1'b0;
        mem_win_s = 1'b0;
        case (state_r)
            MEM_FIRST: begin
                mem_win_s = mem_real_s;
                ex_win_s  = ex_real_s && !mem_real_s;
            end
            EX_FIRST: begin
                ex_win_s  = ex_real_s;
                mem_win_s = mem_real_s && !ex_real_s;
            end
            default: begin
                ex_win_s  = 1'b0;
                mem_win_s = 1'b0;
            end
        endcase
    end

    assign ex_gnt  = nRST && ex_req  && ((ex_rd  == ZERO_REG) || ex_win_s);
    assign mem_gnt = nRST && mem_req && ((mem_rd == ZERO_REG) || mem_win_s);

    // Count consecutive denials of a real ex request; any gap or grant clears it.
    always_comb begin
        starve_cnt_next_s = 4'd0;
        if (ex_real_s && !ex_win_s) begin
            starve_cnt_next_s = (starve_cnt_r == LIMIT) ? starve_cnt_r : (starve_cnt_r + 4'd1);
        end else begin
            starve_cnt_next_s = 4'd0;
        end
    end

    // The denial that reaches the limit hands the next cycle's priority to ex.
    always_comb begin
        state_next_s = MEM_FIRST;
        case (state_r)
            MEM_FIRST: state_next_s = (starve_cnt_next_s == LIMIT) ? EX_FIRST : MEM_FIRST;
            EX_FIRST:  state_next_s = MEM_FIRST;
            default:   state_next_s = MEM_FIRST;
        endcase
    end

    // Arbiter state, starve counter and the registered write port.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r      <= MEM_FIRST;
            starve_cnt_r <= 4'd0;
            rf_RegWrite  <= 1'b0;
            rf_rd        <= ZERO_REG;
            rf_wdata     <= 64'd0;
        end else begin
            state_r      <= state_next_s;
            starve_cnt_r <= starve_cnt_next_s;
            rf_RegWrite  <= mem_win_s || ex_win_s;
            if (mem_win_s) begin
                rf_rd    <= mem_s.rd;
                rf_wdata <= mem_s.wdata;
            end else if (ex_win_s) begin
                rf_rd    <= ex_s.rd;
                rf_wdata <= ex_s.wdata;
            end else begin
                rf_rd    <= rf_rd;
                rf_wdata <= rf_wdata;
            end
        end
    end

    assign rf_rs1 = rs1;
    assign rf_rs2 = rs2;

    rf_fwd_mux u_fwd1 (
        .wr_en    (rf_RegWrite),
        .wr_rd    (rf_rd),
        .wr_data  (rf_wdata),
        .rs       (rs1),
        .rf_rdata (rf_rdata1),
        .rdata    (rdata1)
    );

    rf_fwd_mux u_fwd2 (
        .wr_en    (rf_RegWrite),
        .wr_rd    (rf_rd),
        .wr_data  (rf_wdata),
        .rs       (rs2),
        .rf_rdata (rf_rdata2),
        .rdata    (rdata2)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table plus corner-case sequences.
module tb_regfile_wb_arbiter;
    import types_pkg::*;

    localparam int SL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if wb_if (.CLK(clk));

    regfile_wb_arbiter #(.STARVE_LIMIT(SL)) dut (
        .CLK         (clk),
        .nRST        (wb_if.nRST),
        .ex_req      (wb_if.ex_req),
        .ex_rd       (wb_if.ex_rd),
        .ex_wdata    (wb_if.ex_wdata),
        .ex_gnt      (wb_if.ex_gnt),
        .mem_req     (wb_if.mem_req),
        .mem_rd      (wb_if.mem_rd),
        .mem_wdata   (wb_if.mem_wdata),
        .mem_gnt     (wb_if.mem_gnt),
        .rs1         (wb_if.rs1),
        .rs2         (wb_if.rs2),
        .rf_rs1      (wb_if.rf_rs1),
        .rf_rs2      (wb_if.rf_rs2),
        .rf_rdata1   (wb_if.rf_rdata1),
        .rf_rdata2   (wb_if.rf_rdata2),
        .rdata1      (wb_if.rdata1),
        .rdata2      (wb_if.rdata2),
        .rf_rd       (wb_if.rf_rd),
        .rf_wdata    (wb_if.rf_wdata),
        .rf_RegWrite (wb_if.rf_RegWrite)
    );

    typedef struct {
        logic   exr;  reg_t exrd; dword_t exwd;
        logic   mr;   reg_t mrd;  dword_t mwd;
        logic   eg;   logic mg;
        logic   we;   reg_t rd;   dword_t wd;
    } vec_t;

    typedef struct {
        logic   we;
        reg_t   rd;
        dword_t wd;
    } wr_t;

    vec_t vecs[9];
    wr_t  sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic exr, input reg_t exrd, input dword_t exwd,
                         input logic mr, input reg_t mrd, input dword_t mwd);
        wb_if.ex_req    = exr;
        wb_if.ex_rd     = exrd;
        wb_if.ex_wdata  = exwd;
        wb_if.mem_req   = mr;
        wb_if.mem_rd    = mrd;
        wb_if.mem_wdata = mwd;
    endtask

    // Drive one cycle, check grants mid-cycle, then check the registered write after the edge.
    task automatic run_cycle(input string nm,
                             input logic exr, input reg_t exrd, input dword_t exwd,
                             input logic mr, input reg_t mrd, input dword_t mwd,
                             input logic eg, input logic mg,
                             input logic we, input reg_t rd, input dword_t wd);
        wr_t w;
        drive(exr, exrd, exwd, mr, mrd, mwd);
        @(negedge clk);
        chk({nm, ".ex_gnt"},  64'(wb_if.ex_gnt),  64'(eg));
        chk({nm, ".mem_gnt"}, 64'(wb_if.mem_gnt), 64'(mg));
        sb_q.push_back('{we: we, rd: rd, wd: wd});
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            chk({nm, ".sb_empty"}, 64'd0, 64'd1);
        end else begin
            w = sb_q.pop_front();
            chk({nm, ".RegWrite"}, 64'(wb_if.rf_RegWrite), 64'(w.we));
            chk({nm, ".rf_rd"},    64'(wb_if.rf_rd),       64'(w.rd));
            chk({nm, ".rf_wdata"}, wb_if.rf_wdata,         w.wd);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd5,  64'hDEAD_BEEF_0000_0001, 1'b0, 1'b1, 1'b1, 5'd5,  64'hDEAD_BEEF_0000_0001};
        vecs[1] = '{1'b1, 5'd3,  64'h33,   1'b0, 5'd0,  64'h0,    1'b1, 1'b0, 1'b1, 5'd3,  64'h33};
        vecs[2] = '{1'b1, 5'd0,  64'hE0,   1'b1, 5'd7,  64'h77,   1'b1, 1'b1, 1'b1, 5'd7,  64'h77};
        vecs[3] = '{1'b1, 5'd6,  64'h66,   1'b1, 5'd0,  64'hF0,   1'b1, 1'b1, 1'b1, 5'd6,  64'h66};
        vecs[4] = '{1'b1, 5'd0,  64'h11,   1'b1, 5'd0,  64'h22,   1'b1, 1'b1, 1'b0, 5'd6,  64'h66};
        vecs[5] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 1'b0, 1'b0, 5'd6,  64'h66};
        vecs[6] = '{1'b1, 5'd8,  64'h88,   1'b1, 5'd8,  64'h8080, 1'b0, 1'b1, 1'b1, 5'd8,  64'h8080};
        vecs[7] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b0, 1'b0, 1'b0, 5'd8,  64'h8080};
        vecs[8] = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF};

        wb_if.nRST      = 1'b0;
        wb_if.rs1       = 5'd0;
        wb_if.rs2       = 5'd0;
        wb_if.rf_rdata1 = 64'd0;
        wb_if.rf_rdata2 = 64'd0;
        drive(1'b1, 5'd3, 64'h33, 1'b1, 5'd5, 64'h55);

        // Reset state: outputs cleared and no grants while reset is held.
        #2;
        chk("rst.RegWrite", 64'(wb_if.rf_RegWrite), 64'd0);
        chk("rst.rf_rd",    64'(wb_if.rf_rd),       64'd0);
        chk("rst.rf_wdata", wb_if.rf_wdata,         64'd0);
        chk("rst.ex_gnt",   64'(wb_if.ex_gnt),      64'd0);
        chk("rst.mem_gnt",  64'(wb_if.mem_gnt),     64'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        wb_if.nRST = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_cycle($sformatf("vec%0d", i),
                      vecs[i].exr, vecs[i].exrd, vecs[i].exwd,
                      vecs[i].mr,  vecs[i].mrd,  vecs[i].mwd,
                      vecs[i].eg,  vecs[i].mg,
                      vecs[i].we,  vecs[i].rd,   vecs[i].wd);
        end

        // Starvation: mem wins SL times, then ex is forced through once.
        for (int i = 0; i < 5; i++) begin
            logic exw;
            exw = (i == SL);
            run_cycle($sformatf("starve%0d", i),
                      1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44,
                      exw, !exw, 1'b1, exw ? 5'd3 : 5'd4, exw ? 64'h33 : 64'h44);
        end
        run_cycle("starve_idle", 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                  1'b0, 1'b0, 1'b0, 5'd4, 64'h44);

        // Forwarding of the registered write onto both read ports.
        run_cycle("fwd_wr", 1'b0, 5'd0, 64'h0, 1'b1, 5'd9, 64'h1234,
                  1'b0, 1'b1, 1'b1, 5'd9, 64'h1234);
        wb_if.rs1       = 5'd9;
        wb_if.rs2       = 5'd0;
        wb_if.rf_rdata1 = 64'hAAAA;
        wb_if.rf_rdata2 = 64'h5555;
        #1;
        chk("fwd.rdata1_hit",  wb_if.rdata1,       64'h1234);
        chk("fwd.rdata2_x0",   wb_if.rdata2,       64'h5555);
        chk("fwd.rf_rs1",      64'(wb_if.rf_rs1),  64'd9);
        wb_if.rs1 = 5'd8;
        #1;
        chk("fwd.rdata1_miss", wb_if.rdata1,       64'hAAAA);
        chk("fwd.rf_rs1b",     64'(wb_if.rf_rs1),  64'd8);
        wb_if.rs2 = 5'd9;
        #1;
        chk("fwd.rdata2_hit",  wb_if.rdata2,       64'h1234);
        chk("fwd.rf_rs2",      64'(wb_if.rf_rs2),  64'd9);
        run_cycle("fwd_idle", 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                  1'b0, 1'b0, 1'b0, 5'd9, 64'h1234);
        wb_if.rs1 = 5'd9;
        #1;
        chk("fwd.rdata1_nowe", wb_if.rdata1, 64'hAAAA);
        wb_if.rs1 = 5'd0;
        wb_if.rs2 = 5'd0;

        // ex withdraws after two denials: counter clears, no forced ex win later.
        run_cycle("drop0", 1'b1, 5'd2, 64'h22, 1'b1, 5'd11, 64'hB1,
                  1'b0, 1'b1, 1'b1, 5'd11, 64'hB1);
        run_cycle("drop1", 1'b1, 5'd2, 64'h22, 1'b1, 5'd11, 64'hB2,
                  1'b0, 1'b1, 1'b1, 5'd11, 64'hB2);
        chk("drop.cnt_two", 64'(dut.starve_cnt_r), 64'd2);
        run_cycle("drop2", 1'b0, 5'd2, 64'h22, 1'b1, 5'd11, 64'hB3,
                  1'b0, 1'b1, 1'b1, 5'd11, 64'hB3);
        chk("drop.cnt_clr", 64'(dut.starve_cnt_r), 64'd0);
        for (int i = 0; i < SL; i++) begin
            run_cycle($sformatf("drop_re%0d", i), 1'b1, 5'd2, 64'h22, 1'b1, 5'd12, 64'hC0 + 64'(i),
                      1'b0, 1'b1, 1'b1, 5'd12, 64'hC0 + 64'(i));
        end
        run_cycle("drop_idle", 1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0,
                  1'b0, 1'b0, 1'b0, 5'd12, 64'hC2);

        // Reset mid-cycle with a registered write in flight and ex partially starved.
        run_cycle("pre_rst", 1'b1, 5'd2, 64'h22, 1'b1, 5'd13, 64'hD13,
                  1'b0, 1'b1, 1'b1, 5'd13, 64'hD13);
        drive(1'b1, 5'd2, 64'h22, 1'b1, 5'd10, 64'hA10);
        #3;
        chk("mid.mem_gnt", 64'(wb_if.mem_gnt), 64'd1);
        wb_if.nRST = 1'b0;
        #1;
        chk("mid.RegWrite", 64'(wb_if.rf_RegWrite), 64'd0);
        chk("mid.rf_rd",    64'(wb_if.rf_rd),       64'd0);
        chk("mid.mem_gnt0", 64'(wb_if.mem_gnt),     64'd0);
        chk("mid.ex_gnt0",  64'(wb_if.ex_gnt),      64'd0);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 64'h0, 1'b0, 5'd0, 64'h0);
        #2;
        wb_if.nRST = 1'b1;
        @(posedge clk);
        #1;
        chk("post.state",    64'(dut.state_r),       64'(MEM_FIRST));
        chk("post.cnt",      64'(dut.starve_cnt_r),  64'd0);
        chk("post.RegWrite", 64'(wb_if.rf_RegWrite), 64'd0);
        chk("post.rf_rd",    64'(wb_if.rf_rd),       64'd0);

        chk("sb.drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
